// File: rtl/otter_pkg.sv
// Shared Otter pipeline types: memory access size, register-file
// write-select encodings and the memory-stage state encoding.
package otter_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  // RF_WR_SEL encodings seen by the writeback mux
  localparam logic [1:0] RF_SEL_PC4  = 2'b00;
  localparam logic [1:0] RF_SEL_CSR  = 2'b01;
  localparam logic [1:0] RF_SEL_DOUT = 2'b10;
  localparam logic [1:0] RF_SEL_ALU  = 2'b11;

  // The reserved size code 11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_size = BYTE;
      2'b01:   decode_size = HALF;
      default: decode_size = WORD;
    endcase
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr);
    case (size)
      BYTE:    is_misaligned = 1'b0;
      HALF:    is_misaligned = addr[0];
      default: is_misaligned = (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import otter_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to access size
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = rdata_i;
    case (addr_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    if (addr_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (decode_size(size_i))
      BYTE: begin
        if (unsigned_i) begin
          data_o = {24'h000000, byte_s};
        end else begin
          data_o = {{24{byte_s[7]}}, byte_s};
        end
      end
      HALF: begin
        if (unsigned_i) begin
          data_o = {16'h0000, half_s};
        end else begin
          data_o = {{16{half_s[15]}}, half_s};
        end
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Otter memory-access stage: issues data-memory loads/stores over a
// req/ack bus, stalls upstream while an access is outstanding, and
// registers the MEM/WB pipeline fields for the writeback stage.
module memory_stage
  import otter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RST,
  input  logic        EX_VALID,
  input  logic [31:0] EX_PC_PLUS_FOUR,
  input  logic [31:0] EX_CSR_REG,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] EX_RS2,
  input  logic        EX_MEM_WE,
  input  logic        EX_MEM_RDEN,
  input  logic [1:0]  EX_MEM_SIZE,
  input  logic        EX_MEM_UNSIGNED,
  input  logic        EX_RF_WE,
  input  logic [4:0]  EX_RD,
  input  logic [1:0]  EX_RF_WR_SEL,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  output logic [3:0]  DM_BE,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK,
  output logic        MEM_STALL,
  output logic        MEM_MISALIGN,
  output logic        MEM_BUS_ERR,
  output logic        WB_VALID,
  output logic        WB_RF_WE,
  output logic [4:0]  WB_RD,
  output logic [1:0]  WB_RF_WR_SEL,
  output logic [31:0] WB_PC_PLUS_FOUR,
  output logic [31:0] WB_CSR_REG,
  output logic [31:0] WB_D_OUT_2,
  output logic [31:0] WB_ALU_RESULT
);

  // Last REQ cycle count before the access is abandoned
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  mem_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic        dm_req_q, dm_we_q;
  logic [31:0] dm_addr_q, dm_wdata_q;
  logic [3:0]  dm_be_q;

  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        wb_valid_q, wb_rf_we_q, wb_rf_we_d;
  logic [4:0]  wb_rd_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] wb_pc4_q, wb_csr_q, wb_dout_q, wb_dout_d, wb_alu_q;

  logic        access_s, is_store_s, misalign_s;
  logic        start_s, retire_s, finish_s, stall_s;
  mem_size_t   size_s;
  logic [31:0] wdata_s, load_data_s;
  logic [3:0]  be_s;

  assign access_s   = EX_VALID & (EX_MEM_WE | EX_MEM_RDEN);
  assign is_store_s = EX_MEM_WE;
  assign size_s     = decode_size(EX_MEM_SIZE);
  assign misalign_s = is_misaligned(size_s, EX_ALU_RESULT[1:0]);

  // Upstream holds EX/MEM during REQ, so the EX fields still describe the load
  mem_load_align u_load_align (
    .rdata_i    (DM_RDATA),
    .addr_i     (EX_ALU_RESULT[1:0]),
    .size_i     (EX_MEM_SIZE),
    .unsigned_i (EX_MEM_UNSIGNED),
    .data_o     (load_data_s)
  );

  // Store lane replication and byte enables (loads reuse the enables)
  always_comb begin
    wdata_s = EX_RS2;
    be_s    = 4'b1111;
    case (size_s)
      BYTE: begin
        wdata_s = {4{EX_RS2[7:0]}};
        be_s    = 4'b0001 << EX_ALU_RESULT[1:0];
      end
      HALF: begin
        wdata_s = {2{EX_RS2[15:0]}};
        be_s    = 4'b0011 << {EX_ALU_RESULT[1], 1'b0};
      end
      default: begin
        wdata_s = EX_RS2;
        be_s    = 4'b1111;
      end
    endcase
  end

  // Next-state, retire decision and stall for the access controller
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_s    = 1'b0;
    retire_s   = 1'b0;
    finish_s   = 1'b0;
    stall_s    = 1'b0;
    wb_rf_we_d = 1'b0;
    wb_dout_d  = 32'h0000_0000;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s && !misalign_s) begin
          state_d = REQ;
          cnt_d   = 16'd0;
          start_s = 1'b1;
          stall_s = 1'b1;
        end else if (EX_VALID) begin
          // Non-memory instruction, or a misaligned access that never hits the bus
          retire_s   = 1'b1;
          wb_rf_we_d = EX_RF_WE & ~access_s;
          misalign_d = access_s;
        end else begin
          retire_s = 1'b0;
        end
      end
      REQ: begin
        if (DM_ACK) begin
          state_d    = IDLE;
          finish_s   = 1'b1;
          retire_s   = 1'b1;
          wb_rf_we_d = EX_RF_WE;
          if (is_store_s) begin
            wb_dout_d = 32'h0000_0000;
          end else begin
            wb_dout_d = load_data_s;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          finish_s  = 1'b1;
          retire_s  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MEM_STALL = stall_s & ~MEM_RST;

  // State, timeout counter and registered bus request
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0000_0000;
      dm_wdata_q <= 32'h0000_0000;
      dm_be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_s) begin
        dm_req_q   <= 1'b1;
        dm_we_q    <= is_store_s;
        dm_addr_q  <= {EX_ALU_RESULT[31:2], 2'b00};
        dm_wdata_q <= wdata_s;
        dm_be_q    <= be_s;
      end else if (finish_s) begin
        dm_req_q <= 1'b0;
        dm_we_q  <= 1'b0;
      end else begin
        dm_req_q <= dm_req_q;
        dm_we_q  <= dm_we_q;
      end
    end
  end

  // MEM/WB pipeline register: retire loads all fields, otherwise a bubble
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      wb_valid_q <= 1'b0;
      wb_rf_we_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_sel_q   <= 2'b00;
      wb_pc4_q   <= 32'h0000_0000;
      wb_csr_q   <= 32'h0000_0000;
      wb_dout_q  <= 32'h0000_0000;
      wb_alu_q   <= 32'h0000_0000;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      if (retire_s) begin
        wb_valid_q <= 1'b1;
        wb_rf_we_q <= wb_rf_we_d;
        wb_rd_q    <= EX_RD;
        wb_sel_q   <= EX_RF_WR_SEL;
        wb_pc4_q   <= EX_PC_PLUS_FOUR;
        wb_csr_q   <= EX_CSR_REG;
        wb_dout_q  <= wb_dout_d;
        wb_alu_q   <= EX_ALU_RESULT;
      end else begin
        wb_valid_q <= 1'b0;
        wb_rf_we_q <= 1'b0;
      end
    end
  end

  assign DM_REQ          = dm_req_q;
  assign DM_WE           = dm_we_q;
  assign DM_ADDR         = dm_addr_q;
  assign DM_WDATA        = dm_wdata_q;
  assign DM_BE           = dm_be_q;
  assign MEM_MISALIGN    = misalign_q;
  assign MEM_BUS_ERR     = bus_err_q;
  assign WB_VALID        = wb_valid_q;
  assign WB_RF_WE        = wb_rf_we_q;
  assign WB_RD           = wb_rd_q;
  assign WB_RF_WR_SEL    = wb_sel_q;
  assign WB_PC_PLUS_FOUR = wb_pc4_q;
  assign WB_CSR_REG      = wb_csr_q;
  assign WB_D_OUT_2      = wb_dout_q;
  assign WB_ALU_RESULT   = wb_alu_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_memory_stage;
  import otter_pkg::*;

  localparam int TMO = 4;

  logic        MEM_CLK, MEM_RST;
  logic        EX_VALID, EX_MEM_WE, EX_MEM_RDEN, EX_MEM_UNSIGNED, EX_RF_WE;
  logic [31:0] EX_PC_PLUS_FOUR, EX_CSR_REG, EX_ALU_RESULT, EX_RS2;
  logic [1:0]  EX_MEM_SIZE, EX_RF_WR_SEL;
  logic [4:0]  EX_RD;
  logic        DM_REQ, DM_WE, DM_ACK;
  logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
  logic [3:0]  DM_BE;
  logic        MEM_STALL, MEM_MISALIGN, MEM_BUS_ERR;
  logic        WB_VALID, WB_RF_WE;
  logic [4:0]  WB_RD;
  logic [1:0]  WB_RF_WR_SEL;
  logic [31:0] WB_PC_PLUS_FOUR, WB_CSR_REG, WB_D_OUT_2, WB_ALU_RESULT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_alu = 32'h0;

  typedef struct {
    logic        valid, we, rden, uns, rf_we;
    logic [1:0]  size, sel;
    logic [4:0]  rd;
    logic [31:0] pc4, csr, alu, rs2;
  } instr_t;

  memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST(MEM_RST), .EX_VALID(EX_VALID),
    .EX_PC_PLUS_FOUR(EX_PC_PLUS_FOUR), .EX_CSR_REG(EX_CSR_REG),
    .EX_ALU_RESULT(EX_ALU_RESULT), .EX_RS2(EX_RS2), .EX_MEM_WE(EX_MEM_WE),
    .EX_MEM_RDEN(EX_MEM_RDEN), .EX_MEM_SIZE(EX_MEM_SIZE),
    .EX_MEM_UNSIGNED(EX_MEM_UNSIGNED), .EX_RF_WE(EX_RF_WE), .EX_RD(EX_RD),
    .EX_RF_WR_SEL(EX_RF_WR_SEL), .DM_REQ(DM_REQ), .DM_WE(DM_WE),
    .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_BE(DM_BE),
    .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK), .MEM_STALL(MEM_STALL),
    .MEM_MISALIGN(MEM_MISALIGN), .MEM_BUS_ERR(MEM_BUS_ERR),
    .WB_VALID(WB_VALID), .WB_RF_WE(WB_RF_WE), .WB_RD(WB_RD),
    .WB_RF_WR_SEL(WB_RF_WR_SEL), .WB_PC_PLUS_FOUR(WB_PC_PLUS_FOUR),
    .WB_CSR_REG(WB_CSR_REG), .WB_D_OUT_2(WB_D_OUT_2), .WB_ALU_RESULT(WB_ALU_RESULT)
  );

  initial MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [1:0] sz);
    if (sz == 2'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 32'd1 << (a % 4);
    if (sz == 2'd1) return 32'd3 << (2 * ((a % 4) / 2));
    return 32'd15;
  endfunction

  function automatic instr_t make_ins(input logic v, input logic we, input logic rden,
                                      input logic [1:0] sz, input logic uns,
                                      input logic [31:0] alu, input logic [31:0] rs2);
    instr_t i;
    i.valid = v; i.we = we; i.rden = rden; i.size = sz; i.uns = uns;
    i.alu = alu; i.rs2 = rs2; i.rf_we = 1'b1;
    i.sel = rden ? RF_SEL_DOUT : RF_SEL_ALU;
    i.rd = 5'($urandom_range(1, 31));
    i.pc4 = $urandom(); i.csr = $urandom();
    return i;
  endfunction

  task automatic drive(input instr_t i);
    EX_VALID = i.valid; EX_MEM_WE = i.we; EX_MEM_RDEN = i.rden;
    EX_MEM_SIZE = i.size; EX_MEM_UNSIGNED = i.uns; EX_RF_WE = i.rf_we;
    EX_RD = i.rd; EX_RF_WR_SEL = i.sel; EX_PC_PLUS_FOUR = i.pc4;
    EX_CSR_REG = i.csr; EX_ALU_RESULT = i.alu; EX_RS2 = i.rs2;
  endtask

  task automatic check_retire(input instr_t i, input logic rf_we, input logic mis, input logic berr);
    check("wb_valid", WB_VALID, 32'd1);
    check("wb_rf_we", WB_RF_WE, rf_we);
    check("wb_rd", WB_RD, i.rd);
    check("wb_sel", WB_RF_WR_SEL, i.sel);
    check("wb_pc4", WB_PC_PLUS_FOUR, i.pc4);
    check("wb_csr", WB_CSR_REG, i.csr);
    check("wb_alu", WB_ALU_RESULT, i.alu);
    check("misalign", MEM_MISALIGN, mis);
    check("bus_err", MEM_BUS_ERR, berr);
    check("req_after", DM_REQ, 32'd0);
    prev_alu = i.alu;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, WB_VALID, 32'd0);
    check({tag, "_rf_we"}, WB_RF_WE, 32'd0);
    check({tag, "_hold"}, WB_ALU_RESULT, prev_alu);
  endtask

  // Present one instruction at a negedge and follow it until it retires.
  // waits >= TMO means the bus never acknowledges.
  task automatic run_instr(input instr_t i, input int waits, input logic [31:0] rdata);
    logic acc, mis, tmo;
    int kf;
    acc = i.valid && (i.we || i.rden);
    mis = acc && ref_misaligned(i.size, i.alu);
    drive(i);
    DM_RDATA = $urandom();
    if (!acc || mis) begin
      DM_ACK = 1'($urandom_range(0, 1));
      #1 check("stall_nomem", MEM_STALL, 32'd0);
      @(negedge MEM_CLK);
      DM_ACK = 1'b0;
      if (i.valid) check_retire(i, mis ? 1'b0 : i.rf_we, mis, 1'b0);
      else check_bubble("idle");
    end else begin
      DM_ACK = 1'b0;
      tmo = (waits > TMO - 1);
      kf = tmo ? TMO - 1 : waits;
      #1 check("stall_detect", MEM_STALL, 32'd1);
      @(negedge MEM_CLK);
      check("dm_req", DM_REQ, 32'd1);
      check("dm_we", DM_WE, i.we);
      check("dm_addr", DM_ADDR, i.alu - (i.alu % 4));
      check("dm_be", DM_BE, ref_be(i.alu, i.size));
      if (i.we) check("dm_wdata", DM_WDATA, ref_wdata(i.rs2, i.size));
      check_bubble("req0");
      for (int k = 0; k < kf; k++) begin
        #1 check("stall_wait", MEM_STALL, 32'd1);
        @(negedge MEM_CLK);
        check("req_hold", DM_REQ, 32'd1);
        check("addr_hold", DM_ADDR, i.alu - (i.alu % 4));
        check_bubble("wait");
      end
      if (!tmo) begin
        DM_ACK = 1'b1;
        DM_RDATA = rdata;
      end
      #1 check("stall_final", MEM_STALL, 32'd0);
      @(negedge MEM_CLK);
      DM_ACK = 1'b0;
      check_retire(i, tmo ? 1'b0 : i.rf_we, 1'b0, tmo);
      if (!tmo) check("wb_dout", WB_D_OUT_2, i.we ? 32'h0 : ref_load(rdata, i.alu, i.size, i.uns));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dm_req"}, DM_REQ, 32'd0);
    check({tag, "_dm_we"}, DM_WE, 32'd0);
    check({tag, "_dm_addr"}, DM_ADDR, 32'd0);
    check({tag, "_dm_wdata"}, DM_WDATA, 32'd0);
    check({tag, "_dm_be"}, DM_BE, 32'd0);
    check({tag, "_stall"}, MEM_STALL, 32'd0);
    check({tag, "_mis"}, MEM_MISALIGN, 32'd0);
    check({tag, "_berr"}, MEM_BUS_ERR, 32'd0);
    check({tag, "_wb_valid"}, WB_VALID, 32'd0);
    check({tag, "_wb_rf_we"}, WB_RF_WE, 32'd0);
    check({tag, "_wb_rd"}, WB_RD, 32'd0);
    check({tag, "_wb_sel"}, WB_RF_WR_SEL, 32'd0);
    check({tag, "_wb_pc4"}, WB_PC_PLUS_FOUR, 32'd0);
    check({tag, "_wb_csr"}, WB_CSR_REG, 32'd0);
    check({tag, "_wb_dout"}, WB_D_OUT_2, 32'd0);
    check({tag, "_wb_alu"}, WB_ALU_RESULT, 32'd0);
  endtask

  initial begin
    instr_t ins;
    int kind, waits;
    MEM_RST = 1'b1; DM_ACK = 1'b0; DM_RDATA = 32'h0;
    ins = make_ins(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(ins);
    @(negedge MEM_CLK);
    @(negedge MEM_CLK);
    check_all_zero("reset");
    MEM_RST = 1'b0;

    // ALU instruction
    ins = make_ins(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0);
    ins.sel = RF_SEL_ALU;
    run_instr(ins, 0, 32'h0);
    // lb 0x103 with three wait cycles
    run_instr(make_ins(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0), 3, 32'h80FF_FF7F);
    check("lb_value", WB_D_OUT_2, 32'hFFFF_FF80);
    // lhu 0x102, zero-wait ack
    run_instr(make_ins(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_0102, 32'h0), 0, 32'h80FF_FF7F);
    check("lhu_value", WB_D_OUT_2, 32'h0000_80FF);
    // sh 0x206
    ins = make_ins(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0206, 32'hAAAA_BEEF);
    ins.rf_we = 1'b0;
    run_instr(ins, 1, 32'h0);
    // lw 0x101 misaligned
    run_instr(make_ins(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0101, 32'h0), 0, 32'h0);
    // store and load both requested: store wins, D_OUT_2 = 0
    run_instr(make_ins(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h1234_5678), 2, 32'hDEAD_BEEF);
    // timeout abort, then a plain instruction shows the flag was a single pulse
    run_instr(make_ins(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0800, 32'h0), 100, 32'h0);
    run_instr(make_ins(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0042, 32'h0), 0, 32'h0);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      ins = make_ins(kind != 0, kind >= 6, (kind >= 3 && kind <= 5) || kind == 9,
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom(), $urandom());
      ins.rf_we = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 5);
      run_instr(ins, waits, $urandom());
    end

    // reset while a request is outstanding
    ins = make_ins(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0C00, 32'h0);
    drive(ins);
    DM_ACK = 1'b0;
    @(negedge MEM_CLK);
    check("rst_req_before", DM_REQ, 32'd1);
    MEM_RST = 1'b1;
    #1 check("rst_stall", MEM_STALL, 32'd0);
    @(negedge MEM_CLK);
    check_all_zero("midreq_rst");
    ins.valid = 1'b0;
    drive(ins);
    MEM_RST = 1'b0;
    prev_alu = 32'h0;
    run_instr(make_ins(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0), 0, 32'h0000_7F00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the Otter pipeline, between the EX/MEM register and the writeback stage. Performs data-memory loads and stores over a req/ack bus and holds upstream stages while an access is outstanding. Aligns and extends load data. Registers all writeback-bound fields into the MEM/WB pipeline register that drives the writeback stage's mux inputs and `RF_WR_SEL`.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: `REQ` cycles without `DM_ACK` before the access is aborted (range 1..65535).

Ports:
- MEM_CLK  in  1  stage clock; everything is sampled on its rising edge.
- MEM_RST  in  1  reset, synchronous, active-high.
- EX_VALID  in  1  EX/MEM holds a real instruction.
- EX_PC_PLUS_FOUR, EX_CSR_REG, EX_ALU_RESULT  in  32 each  forwarded values; `EX_ALU_RESULT` is also the byte address.
- EX_RS2  in  32  store data.
- EX_MEM_WE, EX_MEM_RDEN  in  1 each  store / load request.
- EX_MEM_SIZE  in  2  00 byte, 01 half, 10 word (11 is treated as word).
- EX_MEM_UNSIGNED  in  1  zero-extend loads (funct3[2]).
- EX_RF_WE  in  1, EX_RD  in  5, EX_RF_WR_SEL  in  2  register-write controls.
- DM_REQ  out  1, DM_WE  out  1, DM_ADDR  out  32 (bits [1:0]=0), DM_WDATA  out  32, DM_BE  out  4  bus request; all registered.
- DM_RDATA  in  32, DM_ACK  in  1  bus response.
- MEM_STALL  out  1  upstream must hold EX/MEM contents.
- MEM_MISALIGN, MEM_BUS_ERR  out  1 each  one-cycle fault flags, aligned with `WB_VALID`.
- WB_VALID, WB_RF_WE  out  1; WB_RD  out  5; WB_RF_WR_SEL  out  2; WB_PC_PLUS_FOUR, WB_CSR_REG, WB_D_OUT_2, WB_ALU_RESULT  out  32  MEM/WB register.

## Operation
- Access = `EX_VALID & (EX_MEM_WE | EX_MEM_RDEN)`.
  - If both request bits are set, the store wins and `WB_D_OUT_2`=0.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus cycle is issued.
  - The instruction retires immediately with `WB_RF_WE`=0 and `MEM_MISALIGN`=1.
- States:
  - **IDLE**: a non-memory instruction retires into MEM/WB at the next edge. An aligned access latches DM_* registers, clears the timeout counter and moves to `REQ`. `MEM_STALL`=1 in that cycle.
  - **REQ**: `DM_REQ`=1, and `DM_*` stays stable until the state is left.
    - On `DM_ACK`: MEM/WB loads (loads capture formatted `DM_RDATA`), `DM_REQ` drops, next state is `IDLE`, and `MEM_STALL`=0 in the ack cycle.
    - Otherwise the counter increments and `MEM_STALL`=1.
    - When the counter reaches `TIMEOUT_CYCLES`-1 without ack: abort, retire with `WB_RF_WE`=0, pulse `MEM_BUS_ERR`, return to `IDLE`.
- Store lanes:
  - Byte: `DM_WDATA` = rs2[7:0] replicated ×4, `DM_BE` = 0001<<addr[1:0].
  - Half: `DM_WDATA` = rs2[15:0] ×2, `DM_BE` = 0011<<(2·addr[1]).
  - Word: `DM_WDATA` = rs2, `DM_BE` = 1111.
- Loads: select the lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend per `EX_MEM_UNSIGNED`. `DM_BE` reflects the load size.
- Cycles where MEM stalls and does not retire load a bubble: `WB_VALID`=0, `WB_RF_WE`=0, other WB fields hold their values.
- Reset: state `IDLE`, counter 0, every output 0 (`DM_*`, `MEM_STALL`, fault flags, all WB_*).
  - Reset during `REQ` abandons the access: `DM_REQ`=0 after the edge. The bus slave tolerates abandoned requests.

## Timing
- Non-memory instruction and misaligned access: 1 cycle EX/MEM→MEM/WB, no stall.
- Memory access: minimum 2 cycles (detect cycle + 1-cycle ack). Each extra ack wait adds 1 cycle.
- `DM_ACK` is ignored outside `REQ`. `DM_RDATA` is sampled only in the ack cycle.
- `MEM_STALL` is combinational from state, access detect and `DM_ACK`. It is never asserted during reset.

## Structure
- Shared `otter_pkg`:
  - `mem_size_t` (BYTE/HALF/WORD)
  - RF_WR_SEL constants: 00 PC+4, 01 CSR, 10 D_OUT_2, 11 ALU
  - `mem_state_t` (IDLE/REQ)
- Sub-module `mem_load_align` (combinational): `DM_RDATA`, addr[1:0], size, unsigned → 32-bit load value.
- A separate `mem_store_align` is not justified; store alignment stays inline.

## Test plan
- ALU instr, `EX_ALU_RESULT`=0x0000_1234, `RF_WR_SEL`=11 → next edge `WB_VALID`=1, `WB_ALU_RESULT`=0x1234, `MEM_STALL` never 1.
- `lb` addr 0x103, `DM_RDATA`=0x80FF_FF7F, ack after 3 wait cycles → `DM_ADDR`=0x100, `DM_BE`=1000. `WB_D_OUT_2`=0xFFFF_FF80 after 5 cycles. 4 bubbles precede retire.
- `lhu` addr 0x102, same data, zero-wait ack → `WB_D_OUT_2`=0x0000_80FF. `MEM_STALL` high exactly 1 cycle.
- `sh` addr 0x206, rs2=0xAAAA_BEEF → `DM_WDATA`=0xBEEF_BEEF, `DM_BE`=1100, `DM_WE`=1.
- `lw` addr 0x101 → no `DM_REQ`, `MEM_MISALIGN`=1 with `WB_VALID`=1, `WB_RF_WE`=0.
- `TIMEOUT_CYCLES`=4, no ack → `MEM_BUS_ERR` pulse, `WB_RF_WE`=0. Assert `MEM_RST` mid-`REQ` in a second run → `DM_REQ`=0 and all WB_* = 0 after the edge.
